// File: rtl/hicore_alu_issue_queue.sv
// hicore_alu_issue_queue
//   Collapsing issue queue for ALU/LUI/AUIPC micro-ops. Entry 0 is the
//   oldest entry. Operands are captured by snooping the two ROB writeback
//   buses by producer tag. A branch kill marks younger entries so they
//   issue as cancelled ops, and a commit flush empties the queue.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   disp_*               dispatch request (valid/ready) and micro-op fields
//   wb0_*, wb1_*         writeback broadcasts (wb0 wins on a double match)
//   kill_valid/_rob_ptr  kill entries younger than kill_rob_ptr
//   rob_head             oldest ROB pointer, reference point for age compare
//   flush                commit flush
//   i_issue2alu_*        valid/ready/cancel handshake toward the ALU
//   alu_*, *_op          fields of the selected entry (0 when none selected)
//   alu_info             {rob_ptr, wb_info} of the selected entry
module hicore_alu_issue_queue #(
  parameter int DEPTH     = 4,
  parameter int XLEN      = 32,
  parameter int ROB_PTR_W = 4,
  parameter int WB_W      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      disp_valid,
  output logic                      disp_ready,
  input  logic [XLEN-1:0]           disp_src1,
  input  logic [XLEN-1:0]           disp_src2,
  input  logic                      disp_src1_rdy,
  input  logic                      disp_src2_rdy,
  input  logic [ROB_PTR_W-1:0]      disp_src1_tag,
  input  logic [ROB_PTR_W-1:0]      disp_src2_tag,
  input  logic [2:0]                disp_msg,
  input  logic                      disp_dir,
  input  logic                      disp_auipc,
  input  logic                      disp_lui,
  input  logic                      disp_alu,
  input  logic [ROB_PTR_W-1:0]      disp_rob_ptr,
  input  logic [WB_W-1:0]           disp_wb_info,
  input  logic                      wb0_wen,
  input  logic                      wb1_wen,
  input  logic [ROB_PTR_W-1:0]      wb0_ptr,
  input  logic [ROB_PTR_W-1:0]      wb1_ptr,
  input  logic [XLEN-1:0]           wb0_data,
  input  logic [XLEN-1:0]           wb1_data,
  input  logic                      kill_valid,
  input  logic [ROB_PTR_W-1:0]      kill_rob_ptr,
  input  logic [ROB_PTR_W-1:0]      rob_head,
  input  logic                      flush,
  output logic                      i_issue2alu_valid,
  input  logic                      i_issue2alu_ready,
  output logic                      i_issue2alu_cancel,
  output logic [XLEN-1:0]           alu_src1,
  output logic [XLEN-1:0]           alu_src2,
  output logic [2:0]                alu_msg,
  output logic                      alu_dir,
  output logic                      auipc_op,
  output logic                      lui_op,
  output logic                      alu_op,
  output logic [ROB_PTR_W+WB_W-1:0] alu_info
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      src1;
    logic                 src1_rdy;
    logic [ROB_PTR_W-1:0] src1_tag;
    logic [XLEN-1:0]      src2;
    logic                 src2_rdy;
    logic [ROB_PTR_W-1:0] src2_tag;
    logic [2:0]           msg;
    logic                 dir;
    logic                 auipc;
    logic                 lui;
    logic                 alu;
    logic [ROB_PTR_W-1:0] rob_ptr;
    logic [WB_W-1:0]      wb_info;
    logic                 killed;
  } entry_t;

  entry_t           q     [DEPTH];
  entry_t           nxt   [DEPTH];
  // Slots 0..DEPTH-1 mirror the queue, slot DEPTH is the incoming dispatch.
  entry_t           woke  [DEPTH+1];
  entry_t           disp_e;
  entry_t           sel_e;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] cnt_nxt;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             sel_found;
  logic             issue_fire;
  logic             enq_fire;

  // Age relative to rob_head so the compare survives pointer wrap.
  function automatic logic younger(input logic [ROB_PTR_W-1:0] ptr,
                                   input logic [ROB_PTR_W-1:0] head,
                                   input logic [ROB_PTR_W-1:0] kptr);
    logic [ROB_PTR_W-1:0] a;
    logic [ROB_PTR_W-1:0] b;
    a = ptr - head;
    b = kptr - head;
    return a > b;
  endfunction

  always_comb begin
    disp_e          = '0;
    disp_e.valid    = 1'b1;
    disp_e.src1     = disp_src1;
    disp_e.src1_rdy = disp_src1_rdy;
    disp_e.src1_tag = disp_src1_tag;
    disp_e.src2     = disp_src2;
    disp_e.src2_rdy = disp_src2_rdy;
    disp_e.src2_tag = disp_src2_tag;
    disp_e.msg      = disp_msg;
    disp_e.dir      = disp_dir;
    disp_e.auipc    = disp_auipc;
    disp_e.lui      = disp_lui;
    disp_e.alu      = disp_alu;
    disp_e.rob_ptr  = disp_rob_ptr;
    disp_e.wb_info  = disp_wb_info;
  end

  // Wakeup and kill applied to every stored entry and to the dispatch entry.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      woke[i] = q[i];
    end
    woke[DEPTH] = disp_e;
    for (int unsigned i = 0; i <= DEPTH; i++) begin
      if (!woke[i].src1_rdy) begin
        if (wb0_wen && wb0_ptr == woke[i].src1_tag) begin
          woke[i].src1     = wb0_data;
          woke[i].src1_rdy = 1'b1;
        end else if (wb1_wen && wb1_ptr == woke[i].src1_tag) begin
          woke[i].src1     = wb1_data;
          woke[i].src1_rdy = 1'b1;
        end
      end
      if (!woke[i].src2_rdy) begin
        if (wb0_wen && wb0_ptr == woke[i].src2_tag) begin
          woke[i].src2     = wb0_data;
          woke[i].src2_rdy = 1'b1;
        end else if (wb1_wen && wb1_ptr == woke[i].src2_tag) begin
          woke[i].src2     = wb1_data;
          woke[i].src2_rdy = 1'b1;
        end
      end
      if (kill_valid && woke[i].valid &&
          younger(woke[i].rob_ptr, rob_head, kill_rob_ptr)) begin
        woke[i].killed = 1'b1;
      end
    end
  end

  // Oldest-first select from registered state only.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!sel_found && q[i].valid &&
          ((q[i].src1_rdy && q[i].src2_rdy) || q[i].killed)) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
    sel_e = sel_found ? q[sel_idx] : '0;
  end

  assign i_issue2alu_valid  = sel_found & ~flush;
  assign i_issue2alu_cancel = sel_e.killed;
  assign alu_src1           = sel_e.src1;
  assign alu_src2           = sel_e.src2;
  assign alu_msg            = sel_e.msg;
  assign alu_dir            = sel_e.dir;
  assign auipc_op           = sel_e.auipc;
  assign lui_op             = sel_e.lui;
  assign alu_op             = sel_e.alu;
  assign alu_info           = {sel_e.rob_ptr, sel_e.wb_info};

  assign disp_ready = (count < CNT_W'(DEPTH));
  assign issue_fire = i_issue2alu_valid & i_issue2alu_ready;
  assign enq_fire   = disp_valid & disp_ready & ~flush;
  assign wr_idx     = issue_fire ? IDX_W'(count - CNT_W'(1)) : IDX_W'(count);

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      nxt[i] = woke[i];
    end
    // Collapse: everything above the issued slot moves down by one.
    if (issue_fire) begin
      for (int unsigned i = 0; i < DEPTH - 1; i++) begin
        if (IDX_W'(i) >= sel_idx) begin
          nxt[i] = woke[i+1];
        end
      end
      nxt[DEPTH-1] = '0;
    end
    if (enq_fire) begin
      nxt[wr_idx] = woke[DEPTH];
    end
    if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        nxt[i].valid = 1'b0;
      end
    end

    case ({enq_fire, issue_fire})
      2'b10:   cnt_nxt = count + CNT_W'(1);
      2'b01:   cnt_nxt = count - CNT_W'(1);
      default: cnt_nxt = count;
    endcase
    if (flush) begin
      cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q[i] <= '0;
      end
    end else begin
      count <= cnt_nxt;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q[i] <= nxt[i];
      end
    end
  end

endmodule
